// File: rtl/tinyriscv_pkg.sv
// Shared tinyriscv definitions: bus widths, legacy hold-flag encodings and the
// debug-halt state enum used by the pipeline hold controller.
package tinyriscv_pkg;

  localparam int InstAddrBus   = 32;
  localparam int Hold_Flag_Bus = 2;

  localparam logic [Hold_Flag_Bus-1:0] Pipe_Flow  = 2'd0;
  localparam logic [Hold_Flag_Bus-1:0] Pipe_Pause = 2'd1;
  localparam logic [Hold_Flag_Bus-1:0] Pipe_Clear = 2'd2;

  localparam logic HoldEnable = 1'b1;
  localparam logic JumpEnable = 1'b1;

  typedef enum logic [1:0] {
    HALT_RUN    = 2'd0,
    HALT_DRAIN  = 2'd1,
    HALT_HALTED = 2'd2
  } halt_state_e;

endpackage

// File: rtl/pipe_halt_fsm.sv
// Debug-halt sequencer: holds IF while the younger stages drain, then freezes
// the whole pipeline and acknowledges the halt one cycle after draining ends.
module pipe_halt_fsm
  import tinyriscv_pkg::*;
#(
  parameter int NumStages = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  input  logic        flush,
  input  logic        src_hold,
  output logic        hold_first,
  output logic        hold_all,
  output logic        ack,
  output halt_state_e state
);

  localparam int CntW = (NumStages > 1) ? $clog2(NumStages) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(NumStages - 1);

  halt_state_e     state_next;
  logic [CntW-1:0] cnt;
  logic [CntW-1:0] cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HALT_RUN;
      cnt   <= '0;
      ack   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ack   <= (state_next == HALT_HALTED);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hold_first = 1'b0;
    hold_all   = 1'b0;
    case (state)
      HALT_RUN: begin
        // IF stops fetching in the very cycle the request appears.
        if (halt_req) begin
          hold_first = 1'b1;
          state_next = HALT_DRAIN;
          cnt_next   = CntLoad;
        end
      end
      HALT_DRAIN: begin
        hold_first = 1'b1;
        if (!halt_req) begin
          state_next = HALT_RUN;
          cnt_next   = '0;
        end else if (flush) begin
          cnt_next = CntLoad;
        end else if (!src_hold) begin
          // Final drain step lands on zero and enters HALTED together.
          if (cnt <= CntW'(1)) begin
            state_next = HALT_HALTED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CntW'(1);
          end
        end
      end
      HALT_HALTED: begin
        hold_all = 1'b1;
        if (!halt_req) state_next = HALT_RUN;
      end
      default: begin
        state_next = HALT_RUN;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: merges jump/flush, per-source holds and debug
// halt into per-stage hold/flush vectors. Define PIPE_CTRL_PERF_EN for counters.
module pipe_hold_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int NumStages  = 3,
  parameter int NumHoldSrc = 4,
  parameter int StageIdxW  = $clog2(NumStages),
  parameter logic [NumHoldSrc*StageIdxW-1:0] HoldSrcStage = {2'd2, 2'd2, 2'd2, 2'd2}
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     jump_flag_i,
  input  logic [InstAddrBus-1:0]   jump_addr_i,
  input  logic                     flush_req_i,
  input  logic [NumHoldSrc-1:0]    hold_req_i,
  input  logic                     halt_req_i,
  output logic                     halt_ack_o,
  output logic [NumStages-1:0]     stage_hold_o,
  output logic [NumStages-1:0]     stage_flush_o,
  output logic [Hold_Flag_Bus-1:0] hold_flag_o,
  output logic                     jump_flag_o,
  output logic [InstAddrBus-1:0]   jump_addr_o,
  output logic [31:0]              stall_cnt_o,
  output logic [31:0]              flush_cnt_o
);

  logic                 flush_any;
  logic                 src_any;
  logic [NumStages-1:0] src_hold;
  logic [NumStages-1:0] fsm_hold;
  logic                 fsm_hold_first;
  logic                 fsm_hold_all;
  halt_state_e          fsm_state;

  assign jump_flag_o = jump_flag_i;
  assign jump_addr_o = jump_addr_i;
  assign flush_any   = jump_flag_i | flush_req_i;
  assign src_any     = |hold_req_i;

  pipe_halt_fsm #(
    .NumStages(NumStages)
  ) u_halt_fsm (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .halt_req  (halt_req_i),
    .flush     (flush_any),
    .src_hold  (src_any),
    .hold_first(fsm_hold_first),
    .hold_all  (fsm_hold_all),
    .ack       (halt_ack_o),
    .state     (fsm_state)
  );

  assign fsm_hold = {NumStages{fsm_hold_all}} | NumStages'(fsm_hold_first);

  // A source stalling stage d must also stall every older stage below it.
  always_comb begin
    src_hold = '0;
    for (int s = 0; s < NumStages; s++) begin
      for (int k = 0; k < NumHoldSrc; k++) begin
        if (hold_req_i[k] && (int'(HoldSrcStage[k*StageIdxW +: StageIdxW]) >= s))
          src_hold[s] = 1'b1;
      end
    end
  end

  always_comb begin
    stage_hold_o  = '0;
    stage_flush_o = '0;
    if (flush_any) begin
      stage_flush_o = '1;
    end else begin
      stage_hold_o = src_hold | fsm_hold;
      for (int s = 0; s < NumStages - 1; s++)
        stage_flush_o[s+1] = stage_hold_o[s] & ~stage_hold_o[s+1];
    end
  end

  always_comb begin
    hold_flag_o = Pipe_Flow;
    if (flush_any || (fsm_state == HALT_HALTED)) hold_flag_o = Pipe_Clear;
    else if (|stage_hold_o)                     hold_flag_o = Pipe_Pause;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stage_hold_o[0]) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_any)       flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: directed halt/hold/jump scenarios
// plus randomized traffic against a deepest-held-stage reference model.
module tb_pipe_hold_ctrl;
  import tinyriscv_pkg::*;

  localparam int NS = 3;
  localparam int NH = 4;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        flush_req = 1'b0;
  logic [3:0]  hold_req = '0;
  logic        halt_req = 1'b0;
  logic        halt_ack;
  logic [2:0]  stage_hold;
  logic [2:0]  stage_flush;
  logic [1:0]  hold_flag;
  logic        jump_flag_out;
  logic [31:0] jump_addr_out;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Source k stalls stages 0..src_stage[k].
  int src_stage [NH] = '{1, 2, 2, 0};

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_mode = M_RUN;
  int          m_good = 0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  logic        obs_ack;
  logic [2:0]  obs_hold;
  logic [2:0]  obs_flush;
  logic [1:0]  obs_flag;

  pipe_hold_ctrl #(
    .NumStages   (NS),
    .NumHoldSrc  (NH),
    .StageIdxW   (2),
    .HoldSrcStage({2'd0, 2'd2, 2'd2, 2'd1})
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .jump_flag_i  (jump_flag),
    .jump_addr_i  (jump_addr),
    .flush_req_i  (flush_req),
    .hold_req_i   (hold_req),
    .halt_req_i   (halt_req),
    .halt_ack_o   (halt_ack),
    .stage_hold_o (stage_hold),
    .stage_flush_o(stage_flush),
    .hold_flag_o  (hold_flag),
    .jump_flag_o  (jump_flag_out),
    .jump_addr_o  (jump_addr_out),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode  = M_RUN;
    m_good  = 0;
    m_stall = '0;
    m_flush = '0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model.
  task automatic step(input logic jf, input logic [31:0] ja, input logic fr,
                      input logic [3:0] hr, input logic hq);
    int         deep;
    logic       fl;
    logic [2:0] eh;
    logic [2:0] ef;
    logic [1:0] eflag;
    jump_flag = jf;
    jump_addr = ja;
    flush_req = fr;
    hold_req  = hr;
    halt_req  = hq;
    fl   = jf | fr;
    deep = -1;
    for (int k = 0; k < NH; k++)
      if (hr[k] && src_stage[k] > deep) deep = src_stage[k];
    if (m_mode == M_HALTED) deep = NS - 1;
    else if ((m_mode == M_DRAIN || hq) && deep < 0) deep = 0;
    eh = '0;
    ef = '0;
    if (fl) begin
      ef = '1;
    end else begin
      for (int s = 0; s < NS; s++) eh[s] = (s <= deep);
      if (deep >= 0 && deep + 1 < NS) ef[deep+1] = 1'b1;
    end
    if (fl || m_mode == M_HALTED) eflag = Pipe_Clear;
    else if (deep >= 0)           eflag = Pipe_Pause;
    else                          eflag = Pipe_Flow;

    @(negedge clk);
    obs_ack   = halt_ack;
    obs_hold  = stage_hold;
    obs_flush = stage_flush;
    obs_flag  = hold_flag;
    check("stage_hold", 32'(stage_hold), 32'(eh));
    check("stage_flush", 32'(stage_flush), 32'(ef));
    check("hold_flag", 32'(hold_flag), 32'(eflag));
    check("jump_flag", 32'(jump_flag_out), 32'(jf));
    check("jump_addr", jump_addr_out, ja);
    check("halt_ack", 32'(halt_ack), 32'(m_mode == M_HALTED));
    check("stall_cnt", stall_cnt, m_stall);
    check("flush_cnt", flush_cnt, m_flush);

`ifdef PIPE_CTRL_PERF_EN
    if (eh[0]) m_stall = m_stall + 32'd1;
    if (fl)    m_flush = m_flush + 32'd1;
`endif
    case (m_mode)
      M_RUN: if (hq) begin m_mode = M_DRAIN; m_good = 0; end
      M_DRAIN: begin
        if (!hq) m_mode = M_RUN;
        else if (fl) m_good = 0;
        else if (hr == 4'b0000) begin
          m_good++;
          if (m_good >= NS - 1) m_mode = M_HALTED;
        end
      end
      default: if (!hq) m_mode = M_RUN;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    jump_flag = 1'b0;
    flush_req = 1'b0;
    hold_req  = '0;
    halt_req  = 1'b0;
    jump_addr = '0;
    #1;
    model_reset();
    check("rst_ack", 32'(halt_ack), 32'd0);
    check("rst_hold", 32'(stage_hold), 32'd0);
    check("rst_flush", 32'(stage_flush), 32'd0);
    check("rst_flag", 32'(hold_flag), 32'(Pipe_Flow));
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Hold halt_req for 12 cycles, optionally jumping or stalling, and measure ack latency.
  task automatic halt_run(input int jump_at, input int hold_at, input int exp_lat, input string tag);
    int lat;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      step(i == jump_at, 32'h200 + i, 1'b0,
           (hold_at >= 0 && i >= hold_at && i < hold_at + 2) ? 4'b0010 : 4'b0000, 1'b1);
      if (lat < 0 && obs_ack) lat = i;
    end
    check(tag, lat, exp_lat);
    step(1'b0, '0, 1'b0, 4'b0000, 1'b0);
    check({tag, "_ack_still"}, 32'(obs_ack), 32'd1);
    step(1'b0, '0, 1'b0, 4'b0000, 1'b0);
    check({tag, "_ack_drop"}, 32'(obs_ack), 32'd0);
  endtask

  initial begin
    logic halt_lvl;
    do_reset();

    step(1'b0, '0, 1'b0, 4'b0001, 1'b0);
    check("src0_hold", 32'(obs_hold), 32'h3);
    check("src0_flush", 32'(obs_flush), 32'h4);
    check("src0_flag", 32'(obs_flag), 32'(Pipe_Pause));
    step(1'b1, 32'h100, 1'b0, 4'b1111, 1'b0);
    check("jump_hold", 32'(obs_hold), 32'h0);
    check("jump_flush", 32'(obs_flush), 32'h7);
    check("jump_flag", 32'(obs_flag), 32'(Pipe_Clear));
    step(1'b0, '0, 1'b1, 4'b0000, 1'b0);
    step(1'b0, '0, 1'b0, 4'b1000, 1'b0);
    step(1'b0, '0, 1'b0, 4'b0000, 1'b0);

    halt_run(-1, -1, 3, "halt_lat_plain");
    halt_run(-1, 1, 5, "halt_lat_stall");
    halt_run(2, -1, 5, "halt_lat_jump");
    halt_run(8, -1, 3, "halt_lat_jump_halted");

    // Asynchronous reset while halted.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 4'b0000, 1'b1);
    check("pre_rst_ack", 32'(obs_ack), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ack", 32'(halt_ack), 32'd0);
    check("async_rst_hold", 32'(stage_hold), 32'h1);
    model_reset();
    halt_req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 4'b0000, 1'b0);
    step(1'b0, '0, 1'b0, 4'b0000, 1'b1);
    step(1'b0, '0, 1'b0, 4'b0000, 1'b0);

    // Performance counters: 5 stall cycles and 2 jumps from a clean reset.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, 4'b1000, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 32'h40 * i, 1'b0, 4'b0000, 1'b0);
    #2;
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall", stall_cnt, 32'd5);
    check("perf_flush", flush_cnt, 32'd2);
`else
    check("perf_stall", stall_cnt, 32'd0);
    check("perf_flush", flush_cnt, 32'd0);
`endif

    halt_lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) halt_lvl = ~halt_lvl;
      step($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 15) == 0,
           ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000, halt_lvl);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
